// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multiport register file
package rf_pkg;

    localparam int DEFAULT_N    = 32;
    localparam int DEFAULT_NREG = 32;
    localparam int ZERO_IDX     = 0;

    // Address width for a register count; never narrower than one bit.
    function automatic int addrWidth(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write scoreboard with Busy lookup (RF_BYPASS_EN clears Busy early)
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG     = DEFAULT_NREG,
    parameter int ZERO_REG = 1,
    parameter int AW       = addrWidth(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ReadReg1,
    input  logic [AW-1:0] ReadReg2,
    output logic          Busy1,
    output logic          Busy2,
    input  logic [AW-1:0] WriteRegB,
    input  logic          regWriteB,
    input  logic [AW-1:0] IssueReg,
    input  logic          issueValid
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pendingNext;

    function automatic logic isZero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    endfunction

    // Retiring write clears first, then a new issue sets, so issue wins on a tie.
    always_comb begin
        pendingNext = pending;
        if (regWriteB) pendingNext[WriteRegB] = 1'b0;
        if (issueValid) pendingNext[IssueReg] = 1'b1;
        if (ZERO_REG != 0) pendingNext[ZERO_IDX] = 1'b0;
    end

    // Pending vector register; reset beats any same-cycle issue.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pendingNext;
    end

    // Busy lookup per read port; with forwarding a retiring write releases the reader now.
    always_comb begin
        Busy1 = pending[ReadReg1];
        Busy2 = pending[ReadReg2];
`ifdef RF_BYPASS_EN
        if (regWriteB && WriteRegB == ReadReg1 && !(issueValid && IssueReg == ReadReg1)) Busy1 = 1'b0;
        if (regWriteB && WriteRegB == ReadReg2 && !(issueValid && IssueReg == ReadReg2)) Busy2 = 1'b0;
`endif
        if (isZero(ReadReg1)) Busy1 = 1'b0;
        if (isZero(ReadReg2)) Busy2 = 1'b0;
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// rtl/rf_multiport_sb.sv - 2R/2W register file with pending-write scoreboard (optional RF_BYPASS_EN forwarding)
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int NREG     = DEFAULT_NREG,
    parameter int ZERO_REG = 1,
    localparam int AW      = addrWidth(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ReadReg1,
    input  logic [AW-1:0] ReadReg2,
    output logic [N-1:0]  ReadData1,
    output logic [N-1:0]  ReadData2,
    output logic          Busy1,
    output logic          Busy2,
    input  logic [AW-1:0] WriteReg,
    input  logic [N-1:0]  WrData,
    input  logic          regWrite,
    input  logic [AW-1:0] WriteRegB,
    input  logic [N-1:0]  WrDataB,
    input  logic          regWriteB,
    input  logic [AW-1:0] IssueReg,
    input  logic          issueValid,
    output logic          wrConflict
);

    logic [N-1:0] regs [NREG];

    function automatic logic isZero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    endfunction

    // Data array: port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs       <= '{default: '0};
            wrConflict <= 1'b0;
        end else begin
            if (regWrite && !isZero(WriteReg))   regs[WriteReg]  <= WrData;
            if (regWriteB && !isZero(WriteRegB)) regs[WriteRegB] <= WrDataB;
            wrConflict <= regWrite && regWriteB && (WriteReg == WriteRegB) && !isZero(WriteReg);
        end
    end

    // Read port 1: stored value, optionally forwarded from this cycle's writes (B over A).
    always_comb begin
        ReadData1 = regs[ReadReg1];
`ifdef RF_BYPASS_EN
        if (regWriteB && WriteRegB == ReadReg1)     ReadData1 = WrDataB;
        else if (regWrite && WriteReg == ReadReg1)  ReadData1 = WrData;
`endif
        if (isZero(ReadReg1)) ReadData1 = '0;
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        ReadData2 = regs[ReadReg2];
`ifdef RF_BYPASS_EN
        if (regWriteB && WriteRegB == ReadReg2)     ReadData2 = WrDataB;
        else if (regWrite && WriteReg == ReadReg2)  ReadData2 = WrData;
`endif
        if (isZero(ReadReg2)) ReadData2 = '0;
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .WriteRegB  (WriteRegB),
        .regWriteB  (regWriteB),
        .IssueReg   (IssueReg),
        .issueValid (issueValid)
    );

endmodule
